reg_bank_reader: RTL and testbench

Read-side sequencer for the 8 × 32-bit register bank. It selects one of the eight bank outputs, or a run of consecutive ones, and delivers them one word per beat over a valid/ready stream to the bus-read or result path of the factorial datapath. Each word is captured into an output register at load time, so the data stays stable under backpressure even when the bank is written.

---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_read_mux8.sv | 18 +
 rtl/reg_bank_reader.sv | 123 ++++++++++++
 tb/tb_reg_bank_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the register-bank read path.
// Imported by the read mux and the read sequencer.
package reg_bank_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 8;
  localparam int PTR_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/reg_read_mux8.sv
// Combinational 8:1 word select over the register bank outputs.
// Usable by any single-word bank read path.
module reg_read_mux8
  import reg_bank_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0]     d_in [NUM_REGS],
  input  logic [PTR_W-1:0] sel,
  output logic [W-1:0]     d_out
);

  // Pick the addressed bank word.
  always_comb begin
    d_out = d_in[sel];
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Read sequencer: streams a run of bank words, one per beat.
// Each beat is captured at load time so it holds under stall.
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = reg_bank_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = reg_bank_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] d_in0,
  input  logic [DATA_WIDTH-1:0] d_in1,
  input  logic [DATA_WIDTH-1:0] d_in2,
  input  logic [DATA_WIDTH-1:0] d_in3,
  input  logic [DATA_WIDTH-1:0] d_in4,
  input  logic [DATA_WIDTH-1:0] d_in5,
  input  logic [DATA_WIDTH-1:0] d_in6,
  input  logic [DATA_WIDTH-1:0] d_in7,
  input  logic                  rd_req,
  input  logic [PTR_W-1:0]      rd_addr,
  input  logic [PTR_W-1:0]      rd_len,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy
);

  rd_state_e             state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [PTR_W-1:0]      sel;
  logic [DATA_WIDTH-1:0] mux_out;
  logic [DATA_WIDTH-1:0] bank [NUM_REGS];

  // Gather the bank outputs into one array for the mux.
  always_comb begin
    bank[0] = d_in0;
    bank[1] = d_in1;
    bank[2] = d_in2;
    bank[3] = d_in3;
    bank[4] = d_in4;
    bank[5] = d_in5;
    bank[6] = d_in6;
    bank[7] = d_in7;
  end

  reg_read_mux8 #(
    .W(DATA_WIDTH)
  ) u_mux (
    .d_in (bank),
    .sel  (sel),
    .d_out(mux_out)
  );

  // Next-state: load first beat on request, advance on accept.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    sel     = rd_addr;
    unique case (state_q)
      IDLE: begin
        sel = rd_addr;
        if (rd_req) begin
          ptr_d   = rd_addr;
          rem_d   = rd_len;
          data_d  = mux_out;
          last_d  = (rd_len == '0);
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        sel = ptr_q + 3'd1;
        if (rd_ready) begin
          if (rem_q == '0) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ptr_d  = sel;
            data_d = mux_out;
            rem_d  = rem_q - 3'd1;
            last_d = (rem_q == 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign rd_last  = last_q;
  assign busy     = (state_q == SEND);

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader.
// Stimulus pushes expected beats; a monitor pops on accept.
module tb_reg_bank_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din [8];
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic [2:0]  rd_len;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        busy;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  reg_bank_reader dut (
    .clk     (clk),
    .reset   (reset),
    .d_in0   (din[0]),
    .d_in1   (din[1]),
    .d_in2   (din[2]),
    .d_in3   (din[3]),
    .d_in4   (din[4]),
    .d_in5   (din[5]),
    .d_in6   (din[6]),
    .d_in7   (din[7]),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_len  (rd_len),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_last (rd_last),
    .busy    (busy)
  );

  task automatic chk(input string nm,
                     input logic [32:0] act,
                     input logic [32:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Monitor: a beat is accepted when valid&ready hold mid-cycle.
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {rd_last, rd_data}, 33'h0);
      end else begin
        chk("beat", {rd_last, rd_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset    = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = '0;
    rd_len   = '0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = 32'd100 + 32'(i);
    tick();
    tick();
    chk("rst_valid", 33'(rd_valid), 33'h0);
    chk("rst_last", 33'(rd_last), 33'h0);
    chk("rst_busy", 33'(busy), 33'h0);
    chk("rst_data", 33'(rd_data), 33'h0);
    reset = 1'b0;
    tick();

    // Single read
    din[3]  = 32'hDEAD_0003;
    rd_addr = 3'd3;
    rd_len  = 3'd0;
    rd_req  = 1'b1;
    push(32'hDEAD_0003, 1'b1);
    tick();
    rd_req = 1'b0;
    chk("single_v", 33'(rd_valid), 33'h1);
    chk("single_l", 33'(rd_last), 33'h1);
    chk("single_d", 33'(rd_data), 33'hDEAD_0003);
    tick();
    chk("single_idle_v", 33'(rd_valid), 33'h0);
    chk("single_idle_b", 33'(busy), 33'h0);
    din[3] = 32'd103;
    tick();

    // Wrapping burst
    rd_addr = 3'd6;
    rd_len  = 3'd3;
    rd_req  = 1'b1;
    push(32'd106, 1'b0);
    push(32'd107, 1'b0);
    push(32'd100, 1'b0);
    push(32'd101, 1'b1);
    tick();
    rd_req = 1'b0;
    chk("wrap_busy", 33'(busy), 33'h1);
    repeat (4) tick();
    chk("wrap_done_v", 33'(rd_valid), 33'h0);
    chk("wrap_done_b", 33'(busy), 33'h0);

    // Backpressure with bank change during stall
    rd_ready = 1'b0;
    rd_addr  = 3'd0;
    rd_len   = 3'd2;
    rd_req   = 1'b1;
    push(32'd100, 1'b0);
    push(32'd101, 1'b0);
    push(32'd102, 1'b1);
    tick();
    rd_req = 1'b0;
    din[0] = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 33'(rd_data), 33'd100);
      chk("stall_valid", 33'(rd_valid), 33'h1);
    end
    rd_ready = 1'b1;
    repeat (3) tick();
    din[0] = 32'd100;
    chk("bp_done", 33'(busy), 33'h0);

    // Request while busy is ignored
    rd_addr = 3'd0;
    rd_len  = 3'd3;
    rd_req  = 1'b1;
    for (int i = 0; i < 4; i++) push(32'd100 + 32'(i), i == 3);
    tick();
    rd_req = 1'b0;
    tick();
    rd_req  = 1'b1;
    rd_addr = 3'd5;
    rd_len  = 3'd0;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    chk("busy_drop", 33'(busy), 33'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_addr5", 33'(rd_valid), 33'h0);
    end

    // Reset in the middle of an 8-beat read
    rd_addr = 3'd0;
    rd_len  = 3'd7;
    rd_req  = 1'b1;
    push(32'd100, 1'b0);
    push(32'd101, 1'b0);
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    chk("beat2_shown", 33'(rd_data), 33'd102);
    reset    = 1'b1;
    rd_ready = 1'b0;
    tick();
    chk("mrst_v", 33'(rd_valid), 33'h0);
    chk("mrst_l", 33'(rd_last), 33'h0);
    chk("mrst_b", 33'(busy), 33'h0);
    chk("mrst_d", 33'(rd_data), 33'h0);
    reset    = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_quiet", 33'(rd_valid), 33'h0);
    end

    // Back-to-back reads with rd_req held high
    rd_addr = 3'd1;
    rd_len  = 3'd1;
    rd_req  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push(32'd101, 1'b0);
      push(32'd102, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) rd_req = 1'b0;
      chk("b2b_valid", 33'(rd_valid), 33'((i % 3) != 2));
      chk("b2b_last", 33'(rd_last), 33'((i % 3) == 1));
    end
    repeat (3) tick();
    chk("queue_empty", 33'(exp_q.size()), 33'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
